// File: rtl/tristate_bus_port_pkg.sv
// Shared types for the tri-state bus port: FSM encoding and counter width helper.
package tristate_bus_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TURN_ON  = 2'd1,
    ST_DRIVE    = 2'd2,
    ST_TURN_OFF = 2'd3
  } state_t;

  // Bits needed to hold values 0..n
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tristate_buffer_vec.sv
// Vector tri-state pad driver; the only driver of the shared bus from this block.
module tristate_buffer_vec #(
  parameter int WIDTH = 8
) (
  input  logic             oe,
  input  logic [WIDTH-1:0] din,
  inout  wire  [WIDTH-1:0] dout
);

  assign dout = oe ? din : {WIDTH{1'bz}};

endmodule

// File: rtl/tristate_bus_port.sv
// Bidirectional bus port: bursts local words onto a shared tri-state bus with
// turnaround dead cycles, a burst limit and ext_busy abort; samples the bus when idle.
module tristate_bus_port
  import tristate_bus_port_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_BURST   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  input  logic             ext_busy,
  input  logic             rx_en,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             abort,
  inout  wire  [WIDTH-1:0] bus
);

  localparam int BW = cnt_w(MAX_BURST);
  localparam int TW = cnt_w(TURN_CYCLES);
  localparam logic [BW-1:0] BMAX  = BW'(MAX_BURST);
  localparam logic [TW-1:0] TINIT = TW'(TURN_CYCLES - 1);

  state_t           state;
  logic             oe_q;
  logic [WIDTH-1:0] drv_q;
  logic [BW-1:0]    bcnt;
  logic [TW-1:0]    tcnt;

  // ext_busy wins over an accept in the same cycle
  assign tx_ready = (state == ST_DRIVE) && (bcnt < BMAX) && !ext_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      oe_q     <= 1'b0;
      drv_q    <= '0;
      bcnt     <= '0;
      tcnt     <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      abort    <= 1'b0;
    end else begin
      abort    <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          oe_q <= 1'b0;
          if (rx_en) begin
            rx_data  <= bus;
            rx_valid <= 1'b1;
          end
          if (tx_valid && !ext_busy) begin
            state <= ST_TURN_ON;
            tcnt  <= TINIT;
          end
        end
        ST_TURN_ON: begin
          oe_q <= 1'b0;
          if (ext_busy) begin
            state <= ST_TURN_OFF;
            tcnt  <= TINIT;
            abort <= 1'b1;
          end else if (tcnt == '0) begin
            state <= ST_DRIVE;
            bcnt  <= '0;
          end else begin
            tcnt <= tcnt - 1'b1;
          end
        end
        ST_DRIVE: begin
          if (ext_busy) begin
            oe_q  <= 1'b0;
            state <= ST_TURN_OFF;
            tcnt  <= TINIT;
            abort <= 1'b1;
          end else if (bcnt == BMAX || !tx_valid) begin
            // the limit check comes first so a held tx_valid still releases
            oe_q  <= 1'b0;
            state <= ST_TURN_OFF;
            tcnt  <= TINIT;
          end else begin
            drv_q <= tx_data;
            oe_q  <= 1'b1;
            bcnt  <= bcnt + 1'b1;
          end
        end
        ST_TURN_OFF: begin
          oe_q <= 1'b0;
          if (tcnt == '0) state <= ST_IDLE;
          else            tcnt  <= tcnt - 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          oe_q  <= 1'b0;
        end
      endcase
    end
  end

  tristate_buffer_vec #(.WIDTH(WIDTH)) u_buf (
    .oe   (oe_q),
    .din  (drv_q),
    .dout (bus)
  );

endmodule

// File: tb/tb_tristate_bus_port.sv
// Directed bench for tristate_bus_port (WIDTH=8, TURN_CYCLES=1, MAX_BURST=4), pullup on bus.
module tb_tristate_bus_port;
  import tristate_bus_port_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready;
  logic       ext_busy = 1'b0;
  logic       rx_en = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       abort;
  wire  [7:0] bus;

  logic       ext_en = 1'b0;
  logic [7:0] ext_data = '0;
  logic       rand_mode = 1'b0;
  logic       ext_q = 1'b0;
  wire        ext_drv = rand_mode ? ext_q : ext_en;

  int n_cmp = 0;
  int n_bad = 0;
  int contention = 0;
  int drives = 0;

  pullup pu (bus);
  assign bus = ext_drv ? ext_data : 8'bz;

  always #5 clk = ~clk;

  tristate_bus_port #(.WIDTH(8), .TURN_CYCLES(1), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .ext_busy(ext_busy), .rx_en(rx_en), .rx_valid(rx_valid), .rx_data(rx_data),
    .abort(abort), .bus(bus)
  );

  // Other agent enables its driver only after ext_busy has been seen for a full cycle
  always @(posedge clk) ext_q <= ext_busy;

  always @(negedge clk) begin
    if (rand_mode) begin
      if (dut.oe_q && ext_q) contention++;
      if (dut.oe_q) drives++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed burst-limit schedule, one entry per cycle
  localparam logic       BL_V [15] = '{1,1,1,1,1,1,1,1,1,1,1,1,0,0,0};
  localparam logic [7:0] BL_D [15] = '{8'h01,8'h01,8'h01,8'h02,8'h03,8'h04,8'h05,8'h05,
                                       8'h05,8'h05,8'h05,8'h06,8'h00,8'h00,8'h00};
  localparam logic       BL_R [15] = '{0,0,1,1,1,1,0,0,0,0,1,1,1,0,0};
  localparam logic [7:0] BL_B [15] = '{8'hFF,8'hFF,8'hFF,8'h01,8'h02,8'h03,8'h04,8'hFF,
                                       8'hFF,8'hFF,8'hFF,8'h05,8'h06,8'hFF,8'hFF};

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus !== 8'hFF) begin n_bad++; $display("FAIL reset_bus: got %h want ff", bus); end
    n_cmp++; if ({tx_ready, rx_valid, abort} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {tx_ready, rx_valid, abort}); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    #2 rst_n = 1'b1;
    // load rx_data with the pulled-up idle bus so the mid-burst reset has something to clear
    cyc(); rx_en = 1'b1;
    cyc(); rx_en = 1'b0; @(negedge clk);
    n_cmp++; if (rx_data !== 8'hFF) begin n_bad++; $display("FAIL reset_pre_rx: got %h want ff", rx_data); end
    cyc(); tx_valid = 1'b1; tx_data = 8'hA5;
    cyc(); cyc(); cyc(); @(negedge clk);
    n_cmp++; if (bus !== 8'hA5) begin n_bad++; $display("FAIL reset_pre_drive: got %h want a5", bus); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus !== 8'hFF) begin n_bad++; $display("FAIL reset_async_bus: got %h want ff", bus); end
    n_cmp++; if ({tx_ready, rx_valid, abort} !== 3'b000) begin n_bad++; $display("FAIL reset_mid_flags: got %b want 000", {tx_ready, rx_valid, abort}); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_mid_rx_data: got %h want 00", rx_data); end
    tx_valid = 1'b0;
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    cyc(); @(negedge clk);
    n_cmp++; if (dut.state !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, ST_IDLE); end
    n_cmp++; if ({abort, bus} !== {1'b0, 8'hFF}) begin n_bad++; $display("FAIL reset_release: got %b/%h want 0/ff", abort, bus); end
  endtask

  task automatic test_single();
    cyc(); tx_valid = 1'b1; tx_data = 8'h3C; @(negedge clk);
    n_cmp++; if ({tx_ready, bus} !== {1'b0, 8'hFF}) begin n_bad++; $display("FAIL single_t0: got %b/%h want 0/ff", tx_ready, bus); end
    cyc(); @(negedge clk);
    n_cmp++; if ({tx_ready, bus} !== {1'b0, 8'hFF}) begin n_bad++; $display("FAIL single_t1: got %b/%h want 0/ff", tx_ready, bus); end
    cyc(); @(negedge clk);
    n_cmp++; if ({tx_ready, bus} !== {1'b1, 8'hFF}) begin n_bad++; $display("FAIL single_t2: got %b/%h want 1/ff", tx_ready, bus); end
    cyc(); tx_valid = 1'b0; @(negedge clk);
    n_cmp++; if (bus !== 8'h3C) begin n_bad++; $display("FAIL single_t3_bus: got %h want 3c", bus); end
    cyc(); @(negedge clk);
    n_cmp++; if (bus !== 8'hFF) begin n_bad++; $display("FAIL single_t4_bus: got %h want ff", bus); end
    cyc(); @(negedge clk);
    n_cmp++; if (dut.state !== ST_IDLE) begin n_bad++; $display("FAIL single_t5_state: got %0d want %0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_burst_limit();
    for (int t = 0; t < 15; t++) begin
      cyc(); tx_valid = BL_V[t]; tx_data = BL_D[t]; @(negedge clk);
      n_cmp++; if (tx_ready !== BL_R[t]) begin n_bad++; $display("FAIL burst_ready t%0d: got %b want %b", t, tx_ready, BL_R[t]); end
      n_cmp++; if (bus !== BL_B[t]) begin n_bad++; $display("FAIL burst_bus t%0d: got %h want %h", t, bus, BL_B[t]); end
    end
  endtask

  task automatic test_abort();
    cyc(); tx_valid = 1'b1; tx_data = 8'h11; @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL abort_t0_ready: got %b want 0", tx_ready); end
    cyc(); cyc(); @(negedge clk);
    n_cmp++; if ({tx_ready, bus} !== {1'b1, 8'hFF}) begin n_bad++; $display("FAIL abort_t2: got %b/%h want 1/ff", tx_ready, bus); end
    cyc(); tx_data = 8'h22; ext_busy = 1'b1; @(negedge clk);
    n_cmp++; if ({tx_ready, abort, bus} !== {1'b0, 1'b0, 8'h11}) begin n_bad++; $display("FAIL abort_t3: got %b/%b/%h want 0/0/11", tx_ready, abort, bus); end
    cyc(); ext_busy = 1'b0; tx_valid = 1'b0; @(negedge clk);
    n_cmp++; if ({abort, bus} !== {1'b1, 8'hFF}) begin n_bad++; $display("FAIL abort_t4: got %b/%h want 1/ff", abort, bus); end
    cyc(); @(negedge clk);
    n_cmp++; if (abort !== 1'b0) begin n_bad++; $display("FAIL abort_t5_pulse: got %b want 0", abort); end
    n_cmp++; if (dut.state !== ST_IDLE) begin n_bad++; $display("FAIL abort_t5_state: got %0d want %0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_rx();
    cyc(); ext_en = 1'b1; ext_data = 8'h5A; rx_en = 1'b1; @(negedge clk);
    n_cmp++; if (bus !== 8'h5A) begin n_bad++; $display("FAIL rx_ext_bus: got %h want 5a", bus); end
    cyc(); rx_en = 1'b0; ext_en = 1'b0; @(negedge clk);
    n_cmp++; if ({rx_valid, rx_data} !== {1'b1, 8'h5A}) begin n_bad++; $display("FAIL rx_sample: got %b/%h want 1/5a", rx_valid, rx_data); end
    cyc(); @(negedge clk);
    n_cmp++; if ({rx_valid, rx_data} !== {1'b0, 8'h5A}) begin n_bad++; $display("FAIL rx_hold: got %b/%h want 0/5a", rx_valid, rx_data); end
    // rx_en together with tx_valid in IDLE: both act
    cyc(); tx_valid = 1'b1; tx_data = 8'h77; rx_en = 1'b1;
    cyc(); rx_en = 1'b0; @(negedge clk);
    n_cmp++; if ({rx_valid, rx_data} !== {1'b1, 8'hFF}) begin n_bad++; $display("FAIL rx_with_tx: got %b/%h want 1/ff", rx_valid, rx_data); end
    cyc(); rx_en = 1'b1; @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL rx_tx_ready: got %b want 1", tx_ready); end
    cyc(); tx_valid = 1'b0; @(negedge clk);
    n_cmp++; if ({rx_valid, bus} !== {1'b0, 8'h77}) begin n_bad++; $display("FAIL rx_in_drive: got %b/%h want 0/77", rx_valid, bus); end
    cyc(); rx_en = 1'b0; @(negedge clk);
    n_cmp++; if ({rx_valid, rx_data} !== {1'b0, 8'hFF}) begin n_bad++; $display("FAIL rx_ignored: got %b/%h want 0/ff", rx_valid, rx_data); end
    cyc(); cyc();
  endtask

  task automatic test_contention();
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = 8'($urandom);
      ext_busy = ($urandom_range(0, 7) == 0);
      ext_data = 8'($urandom);
      rx_en    = ($urandom_range(0, 3) == 0);
    end
    cyc(); tx_valid = 1'b0; ext_busy = 1'b0; rx_en = 1'b0;
    cyc(); cyc(); cyc();
    rand_mode = 1'b0;
    n_cmp++; if (contention !== 0) begin n_bad++; $display("FAIL contention: got %0d cycles want 0", contention); end
    n_cmp++; if (drives == 0) begin n_bad++; $display("FAIL contention_drives: got %0d drive cycles want >0", drives); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_limit();
    test_abort();
    test_rx();
    test_contention();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
